// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one RAM port between the CPU and DMA requesters with a round-robin FSM.
// Define ARB_CPU_PRIORITY_EN for CPU priority with a DMA starvation guard.
module mem_bus_arbiter #(
    parameter int ADDR_W     = 9,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ack,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic [DATA_W-1:0] dma_rdata,
    output logic              dma_ack,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic [1:0]        gnt
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] DONE   = 2'd2;

    if (MEM_LAT < 1 || MEM_LAT > 4 || STARVE_MAX < 1) begin : g_bad_param
        $error("mem_bus_arbiter: MEM_LAT must be 1..4 and STARVE_MAX >= 1");
    end

    logic [1:0]        state_q, state_d, cnt_q, cnt_d, gnt_q, gnt_d;
    logic              owner_q, owner_d, last_q, last_d, we_q, we_d;
    logic              mem_en_q, mem_en_d, mem_we_q, mem_we_d, busy_q, busy_d;
    logic              cpu_ack_q, cpu_ack_d, dma_ack_q, dma_ack_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d, cpu_rdata_q, cpu_rdata_d, dma_rdata_q, dma_rdata_d;
    logic              pick_dma, contended;

    assign contended = cpu_req & dma_req;

`ifdef ARB_CPU_PRIORITY_EN
    localparam int SW = $clog2(STARVE_MAX + 1);
    logic [SW-1:0] starve_q, starve_d;
    assign pick_dma = dma_req & (~cpu_req | (starve_q == SW'(STARVE_MAX)));
    always_comb begin
        starve_d = starve_q;
        if (state_q == IDLE && (cpu_req | dma_req))
            starve_d = pick_dma ? '0 : (contended ? starve_q + 1'b1 : starve_q);
    end
    always_ff @(posedge Clock or posedge Reset)
        if (Reset) starve_q <= '0;
        else       starve_q <= starve_d;
`else
    // last_q = 1 means DMA won last, so a contended CPU wins next.
    assign pick_dma = dma_req & (~cpu_req | ~last_q);
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        owner_d     = owner_q;
        last_d      = last_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        cpu_rdata_d = cpu_rdata_q;
        dma_rdata_d = dma_rdata_q;
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        cpu_ack_d   = 1'b0;
        dma_ack_d   = 1'b0;
        case (state_q)
            IDLE: if (cpu_req | dma_req) begin
                owner_d  = pick_dma;
                we_d     = pick_dma ? dma_we : cpu_we;
                addr_d   = pick_dma ? dma_addr : cpu_addr;
                wdata_d  = pick_dma ? dma_wdata : cpu_wdata;
                mem_en_d = 1'b1;
                mem_we_d = we_d;
                cnt_d    = 2'(MEM_LAT - 1);
                state_d  = ACCESS;
            end
            ACCESS: if (cnt_q == 2'd0) begin
                cpu_rdata_d = (~owner_q & ~we_q) ? mem_rdata : cpu_rdata_q;
                dma_rdata_d = (owner_q & ~we_q) ? mem_rdata : dma_rdata_q;
                cpu_ack_d   = ~owner_q;
                dma_ack_d   = owner_q;
                state_d     = DONE;
            end else begin
                cnt_d = cnt_q - 2'd1;
            end
            DONE: begin
                last_d  = owner_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        busy_d = state_d != IDLE;
        gnt_d  = busy_d ? (owner_d ? 2'b10 : 2'b01) : 2'b00;
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            owner_q     <= 1'b0;
            last_q      <= 1'b1;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            cpu_rdata_q <= '0;
            dma_rdata_q <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            cpu_ack_q   <= 1'b0;
            dma_ack_q   <= 1'b0;
            busy_q      <= 1'b0;
            gnt_q       <= 2'b00;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            owner_q     <= owner_d;
            last_q      <= last_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            cpu_rdata_q <= cpu_rdata_d;
            dma_rdata_q <= dma_rdata_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            cpu_ack_q   <= cpu_ack_d;
            dma_ack_q   <= dma_ack_d;
            busy_q      <= busy_d;
            gnt_q       <= gnt_d;
        end
    end

    assign cpu_rdata = cpu_rdata_q;
    assign dma_rdata = dma_rdata_q;
    assign cpu_ack   = cpu_ack_q;
    assign dma_ack   = dma_ack_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign busy      = busy_q;
    assign gnt       = gnt_q;
endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares the single-port synchronous RAM between two requesters: the CPU memory interface (MAR/MDR path, driven by the control unit's Read/Write) and the DMA/program-loader port.
- Sequences each RAM access through a small FSM and returns read data with a single-cycle ack.
- Arbitrates fairly (round-robin) when both requesters are active.
- Sits between the datapath MAR/MDR registers and the RAM macro.

Parameters:
- ADDR_W, 9, RAM address width.
- DATA_W, 32, data word width.
- MEM_LAT, 1, RAM read latency in cycles (1..4); number of ACCESS cycles.
- STARVE_MAX, 4, consecutive CPU wins before DMA is forced (used only with ARB_CPU_PRIORITY_EN).

Ports:
- Clock  input  1  system clock, rising edge.
- Reset  input  1  asynchronous, active-high reset.
- cpu_req  input  1  CPU access request; level, held until cpu_ack.
- cpu_we  input  1  1=write, 0=read; sampled at grant.
- cpu_addr  input  ADDR_W  CPU address (from MAR).
- cpu_wdata  input  DATA_W  CPU write data (from MDR).
- cpu_rdata  output  DATA_W  read data to MDR; valid while cpu_ack=1.
- cpu_ack  output  1  one-cycle completion pulse.
- dma_req, dma_we, dma_addr, dma_wdata  input  1/1/ADDR_W/DATA_W  same semantics as the CPU ports.
- dma_rdata  output  DATA_W  DMA read data.
- dma_ack  output  1  DMA completion pulse.
- mem_en  output  1  RAM enable.
- mem_we  output  1  RAM write enable.
- mem_addr  output  ADDR_W  RAM address.
- mem_wdata  output  DATA_W  RAM write data.
- mem_rdata  input  DATA_W  RAM read data, valid MEM_LAT cycles after mem_en.
- busy  output  1  high in ACCESS and DONE.
- gnt  output  2  one-hot owner, {dma,cpu}; 00 in IDLE.

Behaviour:
- All outputs are registered.
- Reset values: all outputs 0; state=IDLE; last_grant=DMA, so the CPU wins the first contention; wait counter=0.
- FSM states: IDLE -> ACCESS -> DONE -> IDLE.
- IDLE:
  - If any req=1, select the owner and latch its addr, wdata and we.
  - Drive mem_en=1, plus mem_we=we, on the first ACCESS cycle only.
  - Set gnt and go to ACCESS with counter=MEM_LAT-1.
  - If no req, stay in IDLE.
- ACCESS:
  - mem_addr is held stable for all ACCESS cycles.
  - Decrement the counter; when it reaches 0, capture mem_rdata into the owner's rdata register and go to DONE.
  - For writes, rdata is not updated.
- DONE:
  - Owner's ack=1 for exactly this cycle.
  - last_grant<=owner; go to IDLE; gnt<=00 on exit.
- Latency: req sampled in IDLE at cycle 0 -> ack high in cycle MEM_LAT+1. Throughput is one access per MEM_LAT+2 cycles.
- Requester rules:
  - Must hold req, we, addr and wdata until it samples ack=1.
  - Must deassert req in the cycle after ack, unless it issues a new request.
  - A req still high in IDLE is treated as a new request.
- Round-robin: if both req=1 in IDLE, grant the requester that is not last_grant. A single requester is always granted.
- rdata registers hold their last value between acks.
- A requester dropping req mid-access is ignored: the access completes and ack still pulses.
- Reset mid-operation: FSM returns to IDLE immediately. mem_en, mem_we, ack, busy and gnt go to 0. An in-flight write may or may not have been applied; no ack is issued.
- Address and data pass through unmodified; no wrap or width conversion.

Optional Feature:
- Macro: ARB_CPU_PRIORITY_EN.
- Defined:
  - On contention the CPU wins, except that after STARVE_MAX consecutive contended CPU grants the DMA wins once.
  - The starve counter increments on each contended CPU grant.
  - It clears on any DMA grant and on Reset.
- Undefined: pure round-robin as above; no starve counter exists.

Test Plan:
- Single CPU read, MEM_LAT=1, RAM[0x010]=0xDEADBEEF: cpu_req at cycle 0 -> mem_en=1 with addr 0x010 at cycle 1; cpu_ack=1 with cpu_rdata=0xDEADBEEF at cycle 2; busy=0 at cycle 3.
- DMA write 0x12345678 to 0x1FF, then CPU read of 0x1FF -> mem_we=1 for one cycle; CPU read returns 0x12345678.
- Both req held continuously for 4 accesses -> grant order CPU, DMA, CPU, DMA; each ack one cycle wide and routed only to its owner.
- MEM_LAT=3: CPU read -> mem_en high one cycle, mem_addr stable 3 cycles, ack at cycle 4.
- Reset asserted during ACCESS of a DMA read -> next cycle all outputs 0 and no dma_ack; a CPU read after release completes normally.
- With ARB_CPU_PRIORITY_EN, STARVE_MAX=4, both req held -> grants CPU×4, DMA, CPU×4, DMA.
